// File: rtl/ssi_pkg.sv
// Shared definitions for the SSI absolute-encoder master.
//   ssi_state_t      : controller state encoding
//   ERR_*            : bit positions inside err_flags
//   gray2bin()       : Gray-to-binary decode of the low 'width' bits
package ssi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOW,
    ST_HIGH,
    ST_RECOVER
  } ssi_state_t;

  localparam int ERR_IDLE_LOW     = 0;
  localparam int ERR_MONO_TIMEOUT = 1;
  localparam int ERR_OVERRUN      = 2;

  // Each binary bit is the XOR of all Gray bits at and above it; bits at or
  // above 'width' are returned as zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/ssi_abs_encoder_if.sv
// Host/pin bundle of one SSI encoder channel.
//   enable, trig, err_clr : request and flag control from the register file
//   ssi_d / ssi_c         : encoder data line in, SSI clock out
//   position, pos_vld     : decoded frame and its update strobe
//   err_flags, busy       : sticky line errors, transfer in progress
// master = the encoder block, slave = register file / pins side.
interface ssi_abs_encoder_if;
  logic        enable;
  logic        trig;
  logic        err_clr;
  logic        ssi_d;
  logic        ssi_c;
  logic [31:0] position;
  logic        pos_vld;
  logic [2:0]  err_flags;
  logic        busy;

  modport master (
    input  enable, trig, err_clr, ssi_d,
    output ssi_c, position, pos_vld, err_flags, busy
  );

  modport slave (
    output enable, trig, err_clr, ssi_d,
    input  ssi_c, position, pos_vld, err_flags, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk_100m  : destination clock
//   rst_n_syn : asynchronous active-low reset, both flops load RST_VAL
//   d         : asynchronous input
//   q         : synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_100m,
  input  logic rst_n_syn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ssi_abs_encoder.sv
// SSI master for absolute position encoders.
//   clk_100m  : system clock
//   rst_n_syn : asynchronous active-low reset
//   bus       : ssi_abs_encoder_if.master (requests, pins, position, flags)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ssi_c high, waiting for poll/trig/pending request
// ST_START   | request accepted with line idle high; next cycle ssi_c falls
// ST_LOW     | ssi_c low for CLK_DIV/2 cycles
// ST_HIGH    | ssi_c high for CLK_DIV/2 cycles; falling edge samples a bit
// ST_RECOVER | wait for encoder monoflop to release ssi_d, then commit
module ssi_abs_encoder
  import ssi_pkg::*;
#(
  parameter int DATA_BITS    = 28,
  parameter int CLK_DIV      = 20,
  parameter int READ_PERIOD  = 1000,
  parameter int GRAY         = 0,
  parameter int MONO_TIMEOUT = 4000
) (
  input logic              clk_100m,
  input logic              rst_n_syn,
  ssi_abs_encoder_if.master bus
);

  localparam int HALF = CLK_DIV / 2;
  localparam int PH_W = $clog2(HALF);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam int RC_W = $clog2(MONO_TIMEOUT + 1);
  localparam int PT_W = $clog2(READ_PERIOD);

  ssi_state_t           state;
  logic [PH_W-1:0]      ph;
  logic [BC_W-1:0]      bit_cnt;
  logic [RC_W-1:0]      rc;
  logic [DATA_BITS-1:0] sr;
  logic [3:0]           frame_cnt;
  logic                 ssi_c_q;
  logic [31:0]          pos_q;
  logic                 pos_vld_q;
  logic [2:0]           err_q;
  logic                 pending;
  logic                 en_q;
  logic [PT_W-1:0]      poll_cnt;

  logic        d_s;
  logic        poll_tc;
  logic        req;
  logic        req_any;
  logic        commit;
  logic        timeout;
  logic        ph_end;
  logic [2:0]  err_set;
  logic [31:0] pos_data;
  logic [31:0] pos_next;

  // Line idles high, so the synchroniser resets to 1 to avoid a false
  // idle-low error on the first request after reset.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_d (
    .clk_100m  (clk_100m),
    .rst_n_syn (rst_n_syn),
    .d         (bus.ssi_d),
    .q         (d_s)
  );

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn)
      poll_cnt <= '0;
    else if (!bus.enable || poll_tc)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + 1'b1;
  end

  assign poll_tc = bus.enable && (poll_cnt == PT_W'(READ_PERIOD - 1));
  assign req     = bus.trig || poll_tc;
  assign req_any = req || pending;
  assign ph_end  = (ph == PH_W'(HALF - 1));
  assign commit  = (state == ST_RECOVER) && d_s && (rc >= RC_W'(CLK_DIV));
  assign timeout = (state == ST_RECOVER) && !d_s && (rc >= RC_W'(MONO_TIMEOUT));

  // Data bits sit zero-extended in pos_data, so OR-ing the frame counter
  // into the top nibble never collides with them (DATA_BITS <= 28).
  assign pos_data = (GRAY != 0) ? gray2bin(32'(sr), DATA_BITS) : 32'(sr);
  assign pos_next = pos_data | {frame_cnt + 4'd1, 28'd0};

  always_comb begin
    err_set = '0;
    if (state == ST_IDLE && req_any && !d_s)
      err_set[ERR_IDLE_LOW] = 1'b1;
    if (timeout)
      err_set[ERR_MONO_TIMEOUT] = 1'b1;
    if (state != ST_IDLE && req && pending)
      err_set[ERR_OVERRUN] = 1'b1;
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      state     <= ST_IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      rc        <= '0;
      sr        <= '0;
      frame_cnt <= '0;
      ssi_c_q   <= 1'b1;
      pos_q     <= '0;
      pos_vld_q <= 1'b0;
      err_q     <= '0;
      pending   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      pos_vld_q <= 1'b0;
      en_q      <= bus.enable;
      // set has priority over a coincident clear
      err_q     <= (err_q & ~{3{bus.err_clr}}) | err_set;

      if (state == ST_IDLE)
        pending <= 1'b0;
      else if (req)
        pending <= 1'b1;
      else if (en_q && !bus.enable)
        pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          ssi_c_q <= 1'b1;
          if (req_any && d_s)
            state <= ST_START;
        end
        ST_START: begin
          ssi_c_q <= 1'b0;
          ph      <= '0;
          bit_cnt <= '0;
          state   <= ST_LOW;
        end
        ST_LOW: begin
          if (ph_end) begin
            ssi_c_q <= 1'b1;
            ph      <= '0;
            state   <= ST_HIGH;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_HIGH: begin
          if (ph_end) begin
            ph <= '0;
            if (bit_cnt < BC_W'(DATA_BITS)) begin
              ssi_c_q <= 1'b0;
              sr      <= {sr[DATA_BITS-2:0], d_s};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_LOW;
            end else begin
              rc    <= '0;
              state <= ST_RECOVER;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_RECOVER: begin
          ssi_c_q <= 1'b1;
          if (commit) begin
            frame_cnt <= frame_cnt + 4'd1;
            pos_q     <= pos_next;
            pos_vld_q <= 1'b1;
            state     <= ST_IDLE;
          end else if (timeout) begin
            state <= ST_IDLE;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        default: begin
          ssi_c_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ssi_c     = ssi_c_q;
  assign bus.position  = pos_q;
  assign bus.pos_vld   = pos_vld_q;
  assign bus.err_flags = err_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule
